// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and width for the memory arbiter
package mem_arb_pkg;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational requester pick
// Data side wins unless it was served last and the fetch side is waiting.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_grant,
  output logic   grant_valid,
  output owner_t grant_owner
);
  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
    if (d_req && !(last_grant == OWN_D && i_req)) grant_owner = OWN_D;
  end
endmodule

// File: rtl/reg_16b.sv
// rtl/reg_16b.sv - 16-bit load-enabled register with synchronous reset
module reg_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);
  logic [15:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (en) val_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign q = val_q;
endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-requester arbiter in front of one shared memory port
// Single outstanding access: IDLE grants, ISSUE presents the command, WAIT awaits m_done.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_done,
  output logic        i_stall,
  output logic        d_done,
  output logic        d_stall,
  output logic [15:0] rdata,
  output logic        m_enable,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic        m_stall,
  input  logic        m_done,
  input  logic [15:0] m_rdata,
  output logic        err
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d, last_grant_q, last_grant_d, pick_owner;
  logic            wr_q, wr_d, err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   addr_q, wdata_q;
  logic            d_req, pick_valid, grant, done, issue;

  assign d_req = d_rd | d_wr;
  assign grant = (state_q == IDLE) && pick_valid;
  assign issue = (state_q == ISSUE);

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (pick_valid),
    .grant_owner (pick_owner)
  );

  reg_16b u_addr (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .d   ((pick_owner == OWN_D) ? d_addr : i_addr),
    .q   (addr_q)
  );

  reg_16b u_wdata (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .d   ((pick_owner == OWN_D) ? d_wdata : '0),
    .q   (wdata_q)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    err_d        = err_q | (d_rd & d_wr);
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = ISSUE;
          owner_d      = pick_owner;
          last_grant_d = pick_owner;
          wr_d         = (pick_owner == OWN_D) && d_wr;
          cnt_d        = '0;
        end
      end
      ISSUE: begin
        if (!m_stall && m_done) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (!m_stall) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_done) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Busy cycle without completion: count it, abandon the access on the last allowed one.
    if (state_q != IDLE && !done) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(MAX_WAIT - 1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign m_enable = !rst && issue;
  assign m_wr     = !rst && issue && wr_q;
  assign m_addr   = (!rst && issue) ? addr_q : '0;
  assign m_wdata  = (!rst && issue) ? wdata_q : '0;
  assign i_done   = !rst && done && (owner_q == OWN_I);
  assign d_done   = !rst && done && (owner_q == OWN_D);
  assign rdata    = (!rst && done) ? m_rdata : '0;
  assign i_stall  = !rst && i_req && !i_done;
  assign d_stall  = !rst && d_req && !d_done;
  assign err      = !rst && err_q;
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: cycles allowed from grant to m_done before timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports i_req  input  1 and i_addr  input  16: instruction fetch read request and address.
REQ-005 SHALL have ports d_rd  input  1, d_wr  input  1, d_addr  input  16 and d_wdata  input  16: data read/write request, address and write data.
REQ-006 SHALL have ports i_done  output  1, i_stall  output  1, d_done  output  1 and d_stall  output  1: per-requester completion and stall.
REQ-007 SHALL have port rdata  output  16: read data, valid only in a done cycle.
REQ-008 SHALL have ports m_enable  output  1, m_wr  output  1, m_addr  output  16 and m_wdata  output  16: shared memory command.
REQ-009 SHALL have ports m_stall  input  1, m_done  input  1 and m_rdata  input  16: shared memory response.
REQ-010 SHALL have port err  output  1: sticky error flag.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE and WAIT, plus a 1-bit owner register (I/D) and a last_grant register.
REQ-012 In IDLE, a pending request SHALL be granted at the clock edge: latch owner, address, wr and wdata; move to ISSUE.
REQ-013 Arbitration: D wins over I, except when last_grant==D and i_req is high, in which case I wins.
REQ-014 In ISSUE, m_enable SHALL be 1 with latched m_addr, m_wr and m_wdata; on a cycle with m_stall==0 the FSM SHALL move to WAIT.
REQ-015 In WAIT, m_enable SHALL be 0; on m_done the FSM SHALL pulse owner's done for that same cycle with rdata=m_rdata, then return to IDLE.
REQ-016 m_done in the ISSUE cycle where m_stall==0 SHALL complete the access directly (ISSUE->IDLE).
REQ-017 Minimum latency SHALL be: request cycle N, grant edge, ISSUE at N+1, done at N+1 earliest, next grant at N+2.
REQ-018 SHALL set i_stall = i_req & ~i_done and d_stall = (d_rd|d_wr) & ~d_done, combinationally.
REQ-019 Requesters SHALL hold request and operands stable until done; a request still high in the IDLE cycle after done is a new request.
REQ-020 The timeout counter SHALL clear on grant and increment in ISSUE/WAIT; reaching MAX_WAIT without m_done SHALL set err and force IDLE with no done pulse.
REQ-021 d_rd & d_wr both high SHALL set err and be treated as a write.
REQ-022 m_done while IDLE SHALL be ignored, with no done and no err.
REQ-023 Addresses and data SHALL be 16 bits, passed unmodified; there is no alignment check.
REQ-024 Once set, err SHALL stay 1 until rst.

Reset
REQ-025 On rst high at a clock edge: FSM to IDLE, owner=I, last_grant=I, counter=0, err=0.
REQ-026 During and after reset, all outputs SHALL be 0 (m_addr=0, m_wdata=0, rdata=0).
REQ-027 Reset mid-access SHALL abandon the in-flight access silently; a later m_done is ignored per REQ-022.
REQ-028 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2), owner encoding (I=1'b0, D=1'b1) and the width constant 16.
REQ-030 Address and wdata latches SHALL reuse the existing reg_16b; the arbitration pick SHALL be one sub-module, mem_arb_pick, purely combinational.
REQ-031 The top level SHALL contain only FSM, counter, err and output muxing; total RTL SHALL be 120-400 lines.

Verification
REQ-032 Reset then i_req=1, i_addr=16'h0010, m_done one cycle after ISSUE with m_rdata=16'h1234 -> m_enable 1 for one cycle, i_done 1 for one cycle, rdata=16'h1234, i_stall 0 after.
REQ-033 i_req and d_rd high together in IDLE, last_grant=I -> D granted first (m_addr=d_addr); I granted in the next IDLE cycle.
REQ-034 d_wr held for two back-to-back accesses while i_req pending -> order D, I, D; I is never starved.
REQ-035 m_stall=1 for 3 cycles in ISSUE -> m_enable held 3+1 cycles with stable m_addr; done follows m_done.
REQ-036 MAX_WAIT=4 with m_done never asserted -> err=1 after 4 busy cycles, FSM IDLE, no done pulse; err stays 1 until rst.
REQ-037 rst asserted in WAIT, then m_done pulse -> no done, err=0, all outputs 0, next request served normally.
